// File: rtl/thread_msg_ctlr.sv
// Thread-control message engine: turns FORK/STOP/JOIN commands into one-cycle
// dispatcher requests, waits for the matching completion, and retries or
// reports an error after a timeout.
module thread_msg_ctlr #(
    parameter int unsigned      DW            = 32,
    parameter int unsigned      AW            = 32,
    parameter int unsigned      MW            = 8,
    parameter int unsigned      CMDW          = 4,
    parameter logic [CMDW-1:0]  CODE_FORK     = CMDW'(1),
    parameter logic [CMDW-1:0]  CODE_STOP     = CMDW'(2),
    parameter logic [CMDW-1:0]  CODE_JOIN     = CMDW'(3),
    parameter logic [MW-1:0]    MSG_FORK      = MW'(1),
    parameter logic [MW-1:0]    MSG_FORK_DONE = MW'(2),
    parameter logic [MW-1:0]    MSG_STOP      = MW'(3),
    parameter logic [MW-1:0]    MSG_STOP_DONE = MW'(4),
    parameter logic [MW-1:0]    MSG_JOIN      = MW'(5),
    parameter logic [MW-1:0]    MSG_JOIN_DONE = MW'(6),
    parameter int unsigned      TIMEOUT       = 255,
    parameter int unsigned      MAX_RETRY     = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_oe,
    input  logic            start,
    input  logic [CMDW-1:0] cmd_code,
    input  logic [DW-1:0]   src0,
    input  logic [DW-1:0]   src1,
    input  logic [AW-1:0]   base_addr_data,
    input  logic            disp_online,
    input  logic [MW-1:0]   msg_in,
    input  logic [DW-1:0]   data_in,
    output logic [MW-1:0]   msg_out,
    output logic            msg_pulse,
    output logic [AW-1:0]   addr_out,
    output logic [DW-1:0]   data_out,
    output logic [DW-1:0]   dst,
    output logic            done,
    output logic            err,
    output logic            busy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        HOLD
    } state_t;

    state_t state, next_state;

    logic [TW-1:0] timer;
    logic [RW-1:0] retry;

    // latched request, replayed unchanged on every retry
    logic [MW-1:0] req_msg;
    logic [MW-1:0] rsp_msg;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;

    logic [DW-1:0] dst_q;
    logic          done_q;
    logic          err_q;

    // decoded view of the current command inputs
    logic [AW-1:0] src0_a;
    logic [DW-1:0] base_d;
    logic          cmd_ok;
    logic [MW-1:0] dec_req;
    logic [MW-1:0] dec_rsp;
    logic [AW-1:0] dec_addr;
    logic [DW-1:0] dec_data;

    logic launch;
    logic reply_hit;
    logic tick_expire;
    logic retry_left;

    // width adaptation between the data and address domains
    generate
        if (DW >= AW) begin : g_src0_trunc
            assign src0_a = src0[AW-1:0];
        end else begin : g_src0_ext
            assign src0_a = {{(AW-DW){1'b0}}, src0};
        end
        if (AW >= DW) begin : g_base_trunc
            assign base_d = base_addr_data[DW-1:0];
        end else begin : g_base_ext
            assign base_d = {{(DW-AW){1'b0}}, base_addr_data};
        end
    endgenerate

    // command decode and request address/data formation
    always_comb begin
        cmd_ok   = 1'b0;
        dec_req  = '0;
        dec_rsp  = '0;
        dec_addr = src0_a + base_addr_data;
        dec_data = ((src1 == '0) ? src0 : src1) + base_d;
        if (cmd_code == CODE_FORK) begin
            cmd_ok  = 1'b1;
            dec_req = MSG_FORK;
            dec_rsp = MSG_FORK_DONE;
        end else if (cmd_code == CODE_STOP) begin
            cmd_ok  = 1'b1;
            dec_req = MSG_STOP;
            dec_rsp = MSG_STOP_DONE;
        end else if (cmd_code == CODE_JOIN) begin
            cmd_ok   = 1'b1;
            dec_req  = MSG_JOIN;
            dec_rsp  = MSG_JOIN_DONE;
            dec_data = src1;
        end
    end

    assign launch      = start && cmd_ok && disp_online;
    assign reply_hit   = (msg_in == rsp_msg);
    assign tick_expire = disp_online && (timer == TW'(TIMEOUT - 1));
    assign retry_left  = (retry < RW'(MAX_RETRY));

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (clk_oe) begin
            state <= next_state;
        end
    end

    // next-state logic; a matching reply wins over a simultaneous timeout
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (reply_hit) begin
                    next_state = HOLD;
                end else if (tick_expire) begin
                    next_state = retry_left ? SEND : HOLD;
                end
            end
            HOLD: begin
                if (!start) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // outputs: request fields only during SEND, result registers passed through
    always_comb begin
        msg_out   = '0;
        msg_pulse = 1'b0;
        addr_out  = '0;
        data_out  = '0;
        if (state == SEND) begin
            msg_out   = req_msg;
            msg_pulse = 1'b1;
            addr_out  = req_addr;
            data_out  = req_data;
        end
        busy = (state != IDLE);
        dst  = dst_q;
        done = done_q;
        err  = err_q;
    end

    // datapath: request latch, timer, retry counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            timer    <= '0;
            retry    <= '0;
            req_msg  <= '0;
            rsp_msg  <= '0;
            req_addr <= '0;
            req_data <= '0;
            dst_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (!clk_oe) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        req_msg  <= dec_req;
                        rsp_msg  <= dec_rsp;
                        req_addr <= dec_addr;
                        req_data <= dec_data;
                        retry    <= '0;
                    end
                end
                SEND: begin
                    timer <= '0;
                end
                WAIT: begin
                    if (disp_online) begin
                        timer <= timer + TW'(1);
                    end
                    if (reply_hit) begin
                        dst_q  <= data_in;
                        done_q <= 1'b1;
                        err_q  <= 1'b0;
                    end else if (tick_expire) begin
                        if (retry_left) begin
                            retry <= retry + RW'(1);
                        end else begin
                            dst_q  <= '0;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!start) begin
                        retry <= '0;
                    end
                end
                default: begin
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thread_msg_ctlr.sv
// Self-checking bench for thread_msg_ctlr: directed scenarios plus randomized
// transactions checked against a behavioural request/response model.
module tb_thread_msg_ctlr;

    localparam int T  = 8;
    localparam int MR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_oe;
    logic        start;
    logic [3:0]  cmd_code;
    logic [31:0] src0, src1, base_addr_data;
    logic        disp_online;
    logic [7:0]  msg_in;
    logic [31:0] data_in;
    logic [7:0]  msg_out;
    logic        msg_pulse;
    logic [31:0] addr_out, data_out, dst;
    logic        done, err, busy;

    int checks = 0;
    int passed = 0;

    thread_msg_ctlr #(.TIMEOUT(T), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .clk_oe(clk_oe), .start(start), .cmd_code(cmd_code),
        .src0(src0), .src1(src1), .base_addr_data(base_addr_data),
        .disp_online(disp_online), .msg_in(msg_in), .data_in(data_in),
        .msg_out(msg_out), .msg_pulse(msg_pulse), .addr_out(addr_out),
        .data_out(data_out), .dst(dst), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: request/response codes indexed by command 1..3
    function automatic logic [7:0] model_req(input int c);
        logic [7:0] tab [1:3];
        tab = '{8'h01, 8'h03, 8'h05};
        return tab[c];
    endfunction

    function automatic logic [7:0] model_rsp(input int c);
        logic [7:0] tab [1:3];
        tab = '{8'h02, 8'h04, 8'h06};
        return tab[c];
    endfunction

    function automatic logic [31:0] model_data(input int c, input logic [31:0] s0,
                                               input logic [31:0] s1, input logic [31:0] b);
        if (c == 3) return s1;
        return ((s1 == 32'h0) ? s0 : s1) + b;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int c, input logic [31:0] s0, input logic [31:0] s1,
                         input logic [31:0] b);
        cmd_code       = 4'(c);
        src0           = s0;
        src1           = s1;
        base_addr_data = b;
        start          = 1'b1;
    endtask

    // finishes an accepted request sitting in SEND: reply then release start
    task automatic reply_and_release(input logic [7:0] code);
        step;
        msg_in  = code;
        data_in = 32'h1;
        step;
        msg_in = 8'h0;
        start  = 1'b0;
        step;
        step;
    endtask

    task automatic test_reset;
        rst = 1'b1; clk_oe = 1'b1; disp_online = 1'b1; msg_in = 8'h0; data_in = '0;
        setup(1, 32'h10, 32'h0, 32'h100);
        step; step;
        checks++;
        if ({msg_out, msg_pulse, addr_out, data_out, dst, done, err, busy} !== '0)
            $display("FAIL reset_outputs: got msg=%h pulse=%b addr=%h data=%h dst=%h done=%b err=%b busy=%b, expected all zero",
                     msg_out, msg_pulse, addr_out, data_out, dst, done, err, busy);
        else passed++;
        start = 1'b0;
        rst   = 1'b0;
        step;
    endtask

    task automatic test_fork;
        setup(1, 32'h10, 32'h0, 32'h100);
        step;
        checks++; if ({msg_pulse, msg_out} !== {1'b1, 8'h01}) $display("FAIL fork_pulse: got pulse=%b msg=%h, expected 1/01", msg_pulse, msg_out); else passed++;
        checks++; if (addr_out !== 32'h110) $display("FAIL fork_addr: got %h, expected 00000110", addr_out); else passed++;
        checks++; if (data_out !== 32'h110) $display("FAIL fork_data: got %h, expected 00000110", data_out); else passed++;
        step;
        checks++; if ({msg_pulse, msg_out, addr_out, data_out} !== '0) $display("FAIL fork_wait_idle_outputs: got pulse=%b msg=%h, expected zeros", msg_pulse, msg_out); else passed++;
        step; step;
        msg_in = 8'h02; data_in = 32'h55;
        step;
        checks++; if ({done, err, dst} !== {1'b1, 1'b0, 32'h55}) $display("FAIL fork_done: got done=%b err=%b dst=%h, expected 1/0/00000055", done, err, dst); else passed++;
        msg_in = 8'h0;
        step;
        checks++; if ({done, busy} !== 2'b01) $display("FAIL fork_hold: got done=%b busy=%b, expected 0/1", done, busy); else passed++;
        start = 1'b0;
        step;
        checks++; if (busy !== 1'b0) $display("FAIL fork_release: got busy=%b, expected 0", busy); else passed++;
    endtask

    task automatic test_stop_wrong_reply;
        setup(2, 32'h10, 32'h20, 32'h100);
        step;
        checks++; if ({msg_out, addr_out, data_out} !== {8'h03, 32'h110, 32'h120}) $display("FAIL stop_request: got msg=%h addr=%h data=%h, expected 03/00000110/00000120", msg_out, addr_out, data_out); else passed++;
        step;
        msg_in = 8'h02; data_in = 32'h33;
        step; step;
        checks++; if (done !== 1'b0) $display("FAIL stop_wrong_reply_ignored: got done=%b, expected 0", done); else passed++;
        msg_in = 8'h04; data_in = 32'hAA;
        step;
        checks++; if ({done, err, dst} !== {1'b1, 1'b0, 32'hAA}) $display("FAIL stop_done: got done=%b err=%b dst=%h, expected 1/0/000000aa", done, err, dst); else passed++;
        msg_in = 8'h0; start = 1'b0;
        step; step;
        checks++; if (busy !== 1'b0) $display("FAIL stop_release: got busy=%b, expected 0", busy); else passed++;
    endtask

    task automatic test_timeout;
        int done_cycle;
        logic exp_pulse;
        done_cycle = (MR + 1) * (T + 1) + 1;
        setup(1, 32'h4, 32'h0, 32'h200);
        step;
        for (int c = 1; c <= done_cycle + 1; c++) begin
            exp_pulse = ((c - 1) % (T + 1) == 0) && ((c - 1) / (T + 1) <= MR);
            checks++; if (msg_pulse !== exp_pulse) $display("FAIL timeout_pulse_c%0d: got %b, expected %b", c, msg_pulse, exp_pulse); else passed++;
            if (exp_pulse) begin
                checks++; if ({msg_out, addr_out} !== {8'h01, 32'h204}) $display("FAIL timeout_resend_c%0d: got msg=%h addr=%h, expected 01/00000204", c, msg_out, addr_out); else passed++;
            end
            checks++; if (done !== (c == done_cycle)) $display("FAIL timeout_done_c%0d: got %b, expected %b", c, done, (c == done_cycle)); else passed++;
            if (c == done_cycle) begin
                checks++; if ({err, dst} !== {1'b1, 32'h0}) $display("FAIL timeout_err: got err=%b dst=%h, expected 1/00000000", err, dst); else passed++;
            end
            step;
        end
        start = 1'b0;
        step;
        checks++; if (busy !== 1'b0) $display("FAIL timeout_release: got busy=%b, expected 0", busy); else passed++;
    endtask

    task automatic test_clock_enable;
        setup(1, 32'h8, 32'h0, 32'h40);
        clk_oe = 1'b1;
        step;
        checks++; if ({msg_pulse, addr_out} !== {1'b1, 32'h48}) $display("FAIL ce_pulse: got pulse=%b addr=%h, expected 1/00000048", msg_pulse, addr_out); else passed++;
        clk_oe = 1'b0;
        step;
        checks++; if ({busy, done} !== 2'b10) $display("FAIL ce_hold_send: got busy=%b done=%b, expected 1/0", busy, done); else passed++;
        clk_oe = 1'b1;
        step;
        checks++; if (msg_pulse !== 1'b0) $display("FAIL ce_wait: got pulse=%b, expected 0", msg_pulse); else passed++;
        clk_oe = 1'b0; msg_in = 8'h02; data_in = 32'h77;
        step;
        checks++; if (done !== 1'b0) $display("FAIL ce_disabled_sample: got done=%b, expected 0", done); else passed++;
        clk_oe = 1'b1;
        step;
        checks++; if ({done, dst} !== {1'b1, 32'h77}) $display("FAIL ce_done: got done=%b dst=%h, expected 1/00000077", done, dst); else passed++;
        clk_oe = 1'b0;
        step;
        checks++; if ({done, dst} !== {1'b0, 32'h77}) $display("FAIL ce_done_drop: got done=%b dst=%h, expected 0/00000077", done, dst); else passed++;
        msg_in = 8'h0; clk_oe = 1'b1; start = 1'b0;
        step;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL ce_release: got busy=%b done=%b, expected 0/0", busy, done); else passed++;
    endtask

    task automatic test_disp_online;
        disp_online = 1'b0;
        setup(1, 32'h1, 32'h0, 32'h1000);
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if ({busy, msg_pulse} !== 2'b00) $display("FAIL disp_offline_%0d: got busy=%b pulse=%b, expected 0/0", i, busy, msg_pulse); else passed++;
        end
        disp_online = 1'b1;
        step;
        checks++; if (msg_pulse !== 1'b1) $display("FAIL disp_online_pulse: got %b, expected 1", msg_pulse); else passed++;
        for (int c = 2; c <= 15; c++) begin
            disp_online = !((c - 1) >= 3 && (c - 1) <= 7);
            step;
            checks++; if (msg_pulse !== (c == 15)) $display("FAIL disp_deferred_c%0d: got pulse=%b, expected %b", c, msg_pulse, (c == 15)); else passed++;
        end
        disp_online = 1'b1;
        step;
        rst = 1'b1; start = 1'b0;
        step;
        checks++; if ({msg_out, msg_pulse, addr_out, data_out, dst, done, err, busy} !== '0) $display("FAIL midreset_outputs: got pulse=%b busy=%b dst=%h, expected zeros", msg_pulse, busy, dst); else passed++;
        rst = 1'b0; msg_in = 8'h02; data_in = 32'h99;
        step; step;
        checks++; if ({done, busy, dst} !== '0) $display("FAIL midreset_late_reply: got done=%b busy=%b dst=%h, expected 0/0/0", done, busy, dst); else passed++;
        msg_in = 8'h0;
    endtask

    task automatic test_wrap;
        setup(1, 32'h20, 32'h0, 32'hFFFF_FFF0);
        step;
        checks++; if ({addr_out, data_out} !== {32'h10, 32'h10}) $display("FAIL wrap_fork: got addr=%h data=%h, expected 00000010/00000010", addr_out, data_out); else passed++;
        reply_and_release(8'h02);
        setup(3, 32'h20, 32'hDEAD, 32'hFFFF_FFF0);
        step;
        checks++; if ({msg_out, addr_out, data_out} !== {8'h05, 32'h10, 32'hDEAD}) $display("FAIL wrap_join: got msg=%h addr=%h data=%h, expected 05/00000010/0000dead", msg_out, addr_out, data_out); else passed++;
        reply_and_release(8'h06);
    endtask

    task automatic test_random;
        int c, w;
        logic [31:0] s0, s1, b, rd;
        logic [7:0] wrong;
        for (int t = 0; t < 40; t++) begin
            c  = int'($urandom_range(0, 7));
            s0 = $urandom();
            s1 = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom();
            b  = $urandom();
            setup(c, s0, s1, b);
            msg_in = 8'h0;
            step;
            if (c >= 1 && c <= 3) begin
                checks++; if ({msg_pulse, msg_out} !== {1'b1, model_req(c)}) $display("FAIL rand%0d_req: got pulse=%b msg=%h, expected 1/%h", t, msg_pulse, msg_out, model_req(c)); else passed++;
                checks++; if (addr_out !== s0 + b) $display("FAIL rand%0d_addr: got %h, expected %h", t, addr_out, s0 + b); else passed++;
                checks++; if (data_out !== model_data(c, s0, s1, b)) $display("FAIL rand%0d_data: got %h, expected %h", t, data_out, model_data(c, s0, s1, b)); else passed++;
                w  = int'($urandom_range(1, T));
                rd = $urandom();
                msg_in = ($urandom_range(0, 1) == 1) ? model_rsp(c) : 8'h0;
                for (int i = 1; i <= w; i++) begin
                    step;
                    checks++; if ({done, msg_pulse} !== 2'b00) $display("FAIL rand%0d_early_w%0d: got done=%b pulse=%b, expected 0/0", t, i, done, msg_pulse); else passed++;
                    wrong = 8'($urandom_range(0, 255));
                    if (wrong == model_rsp(c)) wrong = wrong ^ 8'h01;
                    msg_in  = (i == w) ? model_rsp(c) : wrong;
                    data_in = (i == w) ? rd : $urandom();
                end
                step;
                checks++; if ({done, err, dst} !== {1'b1, 1'b0, rd}) $display("FAIL rand%0d_done: got done=%b err=%b dst=%h, expected 1/0/%h", t, done, err, dst, rd); else passed++;
                msg_in = 8'h0; start = 1'b0;
                step;
                checks++; if ({busy, done} !== 2'b00) $display("FAIL rand%0d_release: got busy=%b done=%b, expected 0/0", t, busy, done); else passed++;
            end else begin
                checks++; if ({busy, msg_pulse} !== 2'b00) $display("FAIL rand%0d_unhandled: got busy=%b pulse=%b, expected 0/0", t, busy, msg_pulse); else passed++;
                start = 1'b0;
                step;
            end
        end
    endtask

    initial begin
        test_reset;
        test_fork;
        test_stop_wrong_reply;
        test_timeout;
        test_clock_enable;
        test_disp_online;
        test_wrap;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
